regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-entry register file: 1 write port with byte strobes and
//  2 independent read ports. Optional registered reads, optional write-to-read
//  bypass, optional hardwired-zero entry 0. Replaces single-register storage in
//  datapaths needing an addressable bank (CPU GPRs, CSR shadows, config banks).
// PARAMETERS
//  NUM_REGS   16  number of entries, >= 2, need not be a power of 2
//  REG_WIDTH  32  bits per entry, multiple of 8
//  READ_REG   1   0: combinational read; 1: read data registered, 1-cycle latency
//  BYPASS     1   1: same-cycle write to read addr returns new (strobe-merged) data
//  ZERO_REG   0   1: entry 0 always reads 0, writes to it dropped
//  localparam AW = max(1, $clog2(NUM_REGS)); SW = REG_WIDTH/8
// PORTS
//  clk        in   1          clock, all state on rising edge
//  rst        in   1          synchronous reset, active-high
//  we_i       in   1          write enable
//  waddr_i    in   AW         write address
//  wdata_i    in   REG_WIDTH  write data
//  wstrb_i    in   SW         byte strobes; bit k enables wdata_i[8k+7:8k]
//  re0_i      in   1          read request, port 0
//  raddr0_i   in   AW         read address, port 0
//  rdata0_o   out  REG_WIDTH  read data, port 0
//  rvalid0_o  out  1          rdata0_o valid
//  re1_i, raddr1_i, rdata1_o, rvalid1_o: identical for port 1
// BEHAVIOUR
//  Reset: all entries <= 0; rdata*_o = 0, rvalid*_o = 0 cycle after rst sampled.
//   rst has priority: write/read in a cycle with rst=1 is discarded.
//  Write: on edge with we_i=1, rst=0, waddr_i < NUM_REGS: for each k with
//   wstrb_i[k]=1, byte k of entry <= wdata_i byte k; other bytes hold.
//   we_i=1 with wstrb_i=0 is a no-op. waddr_i >= NUM_REGS: write dropped.
//   ZERO_REG=1 and waddr_i=0: write dropped.
//  Read value v(a): a >= NUM_REGS -> 0; ZERO_REG=1 and a=0 -> 0; else entry[a].
//   BYPASS=1, we_i=1, a==waddr_i, a valid and writable: v = strobe-merge of
//   wdata_i over entry[a] (i.e. post-write value). BYPASS=0: pre-write value.
//  READ_REG=0: rdata*_o = v(raddr*_i) combinationally; rvalid*_o = re*_i.
//  READ_REG=1: on edge with rst=0, rvalid*_o <= re*_i; if re*_i=1,
//   rdata*_o <= v(raddr*_i); if re*_i=0, rdata*_o holds last value.
//   Latency 1 cycle, full throughput (new read every cycle per port).
//  Ports independent: both may read same address same cycle, identical data.
//  No stall/backpressure; no X on outputs after reset for any address input.
// TESTING
//  1 rst=1 two cycles, then read all addrs both ports -> rdata=0, rvalid=1 only
//    for cycles with re=1 (1 cycle late when READ_REG=1).
//  2 write addr 5 = 0xDEADBEEF strb 0xF, then strb 0x2 data 0x0000AA00 ->
//    read 5 returns 0xDEADAAEF.
//  3 BYPASS=1: same cycle we_i=1 waddr=3 wdata=0x12345678 and re0 raddr0=3 ->
//    rdata0=0x12345678; BYPASS=0 -> previous contents of entry 3.
//  4 ZERO_REG=1: write 0xFFFFFFFF to addr 0 -> read 0 returns 0; NUM_REGS=12:
//    write addr 13 -> dropped, read 13 returns 0, entries 0..11 unchanged.
//  5 back-to-back reads port0 addrs 1,2,3 and port1 addrs 3,2,1 every cycle ->
//    per-port data stream in order, rvalid high 3 consecutive cycles.
//  6 assert rst mid-stream with we_i=1 and re0_i=1 -> write not committed,
//    rvalid0_o=0 next cycle, all entries read back 0 afterwards.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-entry register file: one byte-strobed write port, two independent
// read ports. Optional registered reads, write-to-read bypass and a
// hardwired-zero entry 0.
module regfile_mp #(
  parameter int NUM_REGS  = 16,
  parameter int REG_WIDTH = 32,
  parameter int READ_REG  = 1,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG  = 0,
  localparam int AW = ($clog2(NUM_REGS) > 1) ? $clog2(NUM_REGS) : 1,
  localparam int SW = REG_WIDTH / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we_i,
  input  logic [AW-1:0]        waddr_i,
  input  logic [REG_WIDTH-1:0] wdata_i,
  input  logic [SW-1:0]        wstrb_i,
  input  logic                 re0_i,
  input  logic [AW-1:0]        raddr0_i,
  output logic [REG_WIDTH-1:0] rdata0_o,
  output logic                 rvalid0_o,
  input  logic                 re1_i,
  input  logic [AW-1:0]        raddr1_i,
  output logic [REG_WIDTH-1:0] rdata1_o,
  output logic                 rvalid1_o
);

  logic [REG_WIDTH-1:0] mem [NUM_REGS];
  logic [REG_WIDTH-1:0] wmask;
  logic                 wr_ok;
  logic [AW-1:0]        raddr [2];
  logic [REG_WIDTH-1:0] rd_v  [2];

  assign raddr[0] = raddr0_i;
  assign raddr[1] = raddr1_i;

  // Expand byte strobes to a bit mask and qualify the write address.
  // Addresses beyond NUM_REGS (and entry 0 when hardwired) never match.
  always_comb begin
    wmask = '0;
    for (int k = 0; k < SW; k++)
      wmask[8*k +: 8] = {8{wstrb_i[k]}};
    wr_ok = 1'b0;
    for (int i = 0; i < NUM_REGS; i++)
      if (waddr_i == AW'(i) && !(ZERO_REG != 0 && i == 0))
        wr_ok = we_i;
  end

  // Storage: synchronous clear, strobe-merged byte writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        mem[i] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (waddr_i == AW'(i))
          mem[i] <= (mem[i] & ~wmask) | (wdata_i & wmask);
    end
  end

  // Read value per port; out-of-range and hardwired-zero addresses give 0,
  // optionally returning the post-write value on a same-cycle address hit.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_v[p] = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (raddr[p] == AW'(i) && !(ZERO_REG != 0 && i == 0)) begin
          rd_v[p] = mem[i];
          if (BYPASS != 0 && wr_ok && waddr_i == raddr[p])
            rd_v[p] = (mem[i] & ~wmask) | (wdata_i & wmask);
        end
      end
    end
  end

  generate
    if (READ_REG != 0) begin : g_rd_reg
      // Registered read: valid follows request, data holds when idle.
      always_ff @(posedge clk) begin
        if (rst) begin
          rdata0_o  <= '0;
          rdata1_o  <= '0;
          rvalid0_o <= 1'b0;
          rvalid1_o <= 1'b0;
        end else begin
          rvalid0_o <= re0_i;
          rvalid1_o <= re1_i;
          if (re0_i) rdata0_o <= rd_v[0];
          if (re1_i) rdata1_o <= rd_v[1];
        end
      end
    end else begin : g_rd_comb
      assign rdata0_o  = rd_v[0];
      assign rdata1_o  = rd_v[1];
      assign rvalid0_o = re0_i;
      assign rvalid1_o = re1_i;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp. Instance a: defaults (16 entries, registered
// reads, bypass). Instance b: 12 entries, combinational reads, no bypass,
// hardwired-zero entry 0. Both share the same stimulus.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [3:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [3:0]  wstrb_i;
  logic        re0_i, re1_i;
  logic [3:0]  raddr0_i, raddr1_i;

  logic [31:0] a_rdata0, a_rdata1, b_rdata0, b_rdata1;
  logic        a_rvalid0, a_rvalid1, b_rvalid0, b_rvalid1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  regfile_mp u_a (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .wstrb_i(wstrb_i), .re0_i(re0_i), .raddr0_i(raddr0_i), .rdata0_o(a_rdata0),
    .rvalid0_o(a_rvalid0), .re1_i(re1_i), .raddr1_i(raddr1_i),
    .rdata1_o(a_rdata1), .rvalid1_o(a_rvalid1)
  );

  regfile_mp #(.NUM_REGS(12), .READ_REG(0), .BYPASS(0), .ZERO_REG(1)) u_b (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .wstrb_i(wstrb_i), .re0_i(re0_i), .raddr0_i(raddr0_i), .rdata0_o(b_rdata0),
    .rvalid0_o(b_rvalid0), .re1_i(re1_i), .raddr1_i(raddr1_i),
    .rdata1_o(b_rdata1), .rvalid1_o(b_rvalid1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change at the falling edge; registered outputs are checked at the
  // next falling edge, combinational outputs #1 after the inputs settle.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    we_i = 1'b1; waddr_i = a; wdata_i = d; wstrb_i = s;
    cycle();
    we_i = 1'b0;
  endtask

  logic [31:0] b_exp [12];
  logic [31:0] seq   [3];

  initial begin
    rst = 1'b1; we_i = 1'b0; waddr_i = '0; wdata_i = '0; wstrb_i = '0;
    re0_i = 1'b0; re1_i = 1'b0; raddr0_i = '0; raddr1_i = '0;
    @(negedge clk);
    cycle();
    cycle();
    chk("rst_a_rvalid0", {31'b0, a_rvalid0}, 32'd0);
    chk("rst_a_rdata0", a_rdata0, 32'd0);
    chk("rst_a_rvalid1", {31'b0, a_rvalid1}, 32'd0);
    rst = 1'b0;

    // all addresses read zero after reset, both ports
    for (int a = 0; a < 16; a++) begin
      re0_i = 1'b1; re1_i = 1'b1; raddr0_i = 4'(a); raddr1_i = 4'(15 - a);
      #1;
      chk("t1_b_rdata0", b_rdata0, 32'd0);
      chk("t1_b_rvalid0", {31'b0, b_rvalid0}, 32'd1);
      cycle();
      chk("t1_a_rdata0", a_rdata0, 32'd0);
      chk("t1_a_rdata1", a_rdata1, 32'd0);
      chk("t1_a_rvalid0", {31'b0, a_rvalid0}, 32'd1);
    end
    re0_i = 1'b0; re1_i = 1'b0;
    #1;
    chk("t1_b_rvalid0_idle", {31'b0, b_rvalid0}, 32'd0);
    cycle();
    chk("t1_a_rvalid0_idle", {31'b0, a_rvalid0}, 32'd0);
    chk("t1_a_rvalid1_idle", {31'b0, a_rvalid1}, 32'd0);

    // byte strobe merge
    wr(4'd5, 32'hDEADBEEF, 4'hF);
    wr(4'd5, 32'h0000AA00, 4'h2);
    re0_i = 1'b1; raddr0_i = 4'd5;
    #1;
    chk("t2_b_rd5", b_rdata0, 32'hDEADAAEF);
    cycle();
    chk("t2_a_rd5", a_rdata0, 32'hDEADAAEF);

    // same-cycle write/read: a bypasses, b returns old contents
    wr(4'd3, 32'hCAFEF00D, 4'hF);
    we_i = 1'b1; waddr_i = 4'd3; wdata_i = 32'h12345678; wstrb_i = 4'hF;
    re0_i = 1'b1; raddr0_i = 4'd3;
    #1;
    chk("t3_b_nobypass", b_rdata0, 32'hCAFEF00D);
    cycle();
    chk("t3_a_bypass", a_rdata0, 32'h12345678);
    we_i = 1'b1; waddr_i = 4'd3; wdata_i = 32'hAABBCCDD; wstrb_i = 4'h1;
    #1;
    chk("t3_b_nobypass_part", b_rdata0, 32'h12345678);
    cycle();
    chk("t3_a_bypass_part", a_rdata0, 32'h123456DD);
    we_i = 1'b0;
    #1;
    chk("t3_b_after", b_rdata0, 32'h123456DD);
    re0_i = 1'b0;

    // hardwired zero and out-of-range writes
    we_i = 1'b1; waddr_i = 4'd0; wdata_i = 32'hFFFFFFFF; wstrb_i = 4'hF;
    re1_i = 1'b1; raddr1_i = 4'd0;
    #1;
    chk("t4_b_zero_bypass", b_rdata1, 32'd0);
    cycle();
    chk("t4_a_entry0_bypass", a_rdata1, 32'hFFFFFFFF);
    we_i = 1'b0;
    #1;
    chk("t4_b_zero", b_rdata1, 32'd0);
    cycle();
    chk("t4_a_entry0", a_rdata1, 32'hFFFFFFFF);
    re1_i = 1'b0;
    wr(4'd13, 32'h13131313, 4'hF);
    re0_i = 1'b1; raddr0_i = 4'd13;
    #1;
    chk("t4_b_rd13", b_rdata0, 32'd0);
    cycle();
    chk("t4_a_rd13", a_rdata0, 32'h13131313);
    for (int i = 0; i < 12; i++) b_exp[i] = 32'd0;
    b_exp[3] = 32'h123456DD;
    b_exp[5] = 32'hDEADAAEF;
    for (int i = 0; i < 12; i++) begin
      raddr0_i = 4'(i); raddr1_i = 4'(i);
      #1;
      chk("t4_b_bank0", b_rdata0, b_exp[i]);
      chk("t4_b_bank1", b_rdata1, b_exp[i]);
    end
    re0_i = 1'b0;

    // back-to-back reads, both ports, opposite orders
    wr(4'd1, 32'h11111111, 4'hF);
    wr(4'd2, 32'h22222222, 4'hF);
    seq[0] = 32'h11111111; seq[1] = 32'h22222222; seq[2] = 32'h123456DD;
    for (int k = 0; k < 3; k++) begin
      re0_i = 1'b1; re1_i = 1'b1; raddr0_i = 4'(k + 1); raddr1_i = 4'(3 - k);
      #1;
      chk("t5_b_stream0", b_rdata0, seq[k]);
      chk("t5_b_stream1", b_rdata1, seq[2 - k]);
      cycle();
      chk("t5_a_stream0", a_rdata0, seq[k]);
      chk("t5_a_stream1", a_rdata1, seq[2 - k]);
      chk("t5_a_rvalid0", {31'b0, a_rvalid0}, 32'd1);
      chk("t5_a_rvalid1", {31'b0, a_rvalid1}, 32'd1);
    end
    re0_i = 1'b0; re1_i = 1'b0; raddr0_i = 4'd5;
    cycle();
    chk("t5_a_rvalid0_end", {31'b0, a_rvalid0}, 32'd0);
    chk("t5_a_hold0", a_rdata0, 32'h123456DD);

    // reset wins over a concurrent write and read
    rst = 1'b1; we_i = 1'b1; waddr_i = 4'd7; wdata_i = 32'h77777777; wstrb_i = 4'hF;
    re0_i = 1'b1; raddr0_i = 4'd5;
    cycle();
    chk("t6_a_rvalid0", {31'b0, a_rvalid0}, 32'd0);
    chk("t6_a_rdata0", a_rdata0, 32'd0);
    rst = 1'b0; we_i = 1'b0;
    for (int a = 0; a < 16; a++) begin
      re0_i = 1'b1; re1_i = 1'b1; raddr0_i = 4'(a); raddr1_i = 4'(a);
      #1;
      chk("t6_b_clear", b_rdata0, 32'd0);
      cycle();
      chk("t6_a_clear0", a_rdata0, 32'd0);
      chk("t6_a_clear1", a_rdata1, 32'd0);
    end
    re0_i = 1'b0; re1_i = 1'b0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
